// File: rtl/aes_pkg.sv
// Shared types, layout constants and row-shift helpers for the AES round sequencer.
// Byte k of a 128-bit state is bits [8k+7:8k]; column c holds bytes 4c..4c+3, row r = byte r of a column.
package aes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SUB  = 2'd1,
    ST_MIX  = 2'd2,
    ST_DONE = 2'd3
  } seq_state_t;

  localparam int N_COLS = 4;
  localparam int N_ROWS = 4;
  localparam int BYTE_W = 8;
  localparam int COL_W  = 32;
  localparam int BLK_W  = 128;

  function automatic logic [BLK_W-1:0] shift_rows(input logic [BLK_W-1:0] s);
    logic [BLK_W-1:0] o;
    o = '0;
    for (int c = 0; c < N_COLS; c++) begin
      for (int r = 0; r < N_ROWS; r++) begin
        o[(N_ROWS*c + r)*BYTE_W +: BYTE_W] = s[(N_ROWS*((c + r) % N_COLS) + r)*BYTE_W +: BYTE_W];
      end
    end
    return o;
  endfunction

  function automatic logic [BLK_W-1:0] inv_shift_rows(input logic [BLK_W-1:0] s);
    logic [BLK_W-1:0] o;
    o = '0;
    for (int c = 0; c < N_COLS; c++) begin
      for (int r = 0; r < N_ROWS; r++) begin
        o[(N_ROWS*c + r)*BYTE_W +: BYTE_W] =
          s[(N_ROWS*((c - r + N_COLS) % N_COLS) + r)*BYTE_W +: BYTE_W];
      end
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_v1_round_seq_if.sv
// Word-unit request/response bus: one 32-bit column operand out, one 32-bit result back.
// A word transfers on any cycle where req_valid and rsp_ready are both high.
interface aes_v1_round_seq_if;
  import aes_pkg::*;

  logic             req_valid;
  logic             req_dec;
  logic             req_mix;
  logic [COL_W-1:0] req_rs1;
  logic             rsp_ready;
  logic [COL_W-1:0] rsp_rd;

  modport master (
    output req_valid, req_dec, req_mix, req_rs1,
    input  rsp_ready, rsp_rd
  );

  modport slave (
    input  req_valid, req_dec, req_mix, req_rs1,
    output rsp_ready, rsp_rd
  );

endinterface

// File: rtl/aes_shift_rows.sv
// Combinational ShiftRows / InvShiftRows over a full 128-bit state (zero latency).
module aes_shift_rows
  import aes_pkg::*;
(
  input  logic [BLK_W-1:0] in,
  input  logic             inv,
  output logic [BLK_W-1:0] out
);

  assign out = inv ? inv_shift_rows(in) : shift_rows(in);

endmodule

// File: rtl/aes_v1_round_seq.sv
// One AES round: 4 SubBytes words then 4 MixColumns words via the word unit; shift and key add local.
// Zero-wait latency 9 cycles (5 for a final round); every responder stall cycle adds one.
module aes_v1_round_seq
  import aes_pkg::*;
#(
  parameter bit DECRYPT_EN = 1'b1
)
(
  input  logic             g_clk,
  input  logic             g_reset,
  input  logic             start_i,
  input  logic             dec_i,
  input  logic             final_i,
  input  logic [BLK_W-1:0] state_i,
  input  logic [BLK_W-1:0] rkey_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [BLK_W-1:0] result_o,
  aes_v1_round_seq_if.master word
);

  seq_state_t       st, st_nxt;
  logic [1:0]       idx;
  logic [BLK_W-1:0] s_q, k_q;
  logic             dec_q, fin_q;
  logic [BLK_W-1:0] s_wr, sr_out, s_nxt;
  logic             hs, last;

  assign hs   = word.req_valid & word.rsp_ready;
  assign last = hs & (idx == 2'd3);

  // Only the addressed column takes the response, so rsp_rd is never observed without a handshake.
  always_comb begin
    s_wr = s_q;
    s_wr[COL_W*idx +: COL_W] = word.rsp_rd;
  end

  aes_shift_rows u_shift (
    .in  (s_wr),
    .inv (dec_q),
    .out (sr_out)
  );

  always_comb begin
    st_nxt = st;
    case (st)
      ST_IDLE: if (start_i) st_nxt = ST_SUB;
      ST_SUB:  if (last) st_nxt = fin_q ? ST_DONE : ST_MIX;
      ST_MIX:  if (last) st_nxt = ST_DONE;
      ST_DONE: st_nxt = ST_IDLE;
      default: st_nxt = ST_IDLE;
    endcase
  end

  // Inverse rounds add the key before InvMixColumns, so the key goes in at the end of SUB.
  always_comb begin
    s_nxt = s_q;
    case (st)
      ST_IDLE: if (start_i) s_nxt = state_i;
      ST_SUB: begin
        if (last)    s_nxt = (dec_q | fin_q) ? (sr_out ^ k_q) : sr_out;
        else if (hs) s_nxt = s_wr;
      end
      ST_MIX: begin
        if (last)    s_nxt = dec_q ? s_wr : (s_wr ^ k_q);
        else if (hs) s_nxt = s_wr;
      end
      default: s_nxt = s_q;
    endcase
  end

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      st       <= ST_IDLE;
      idx      <= 2'd0;
      s_q      <= '0;
      k_q      <= '0;
      dec_q    <= 1'b0;
      fin_q    <= 1'b0;
      result_o <= '0;
    end else begin
      st  <= st_nxt;
      s_q <= s_nxt;
      if (st == ST_IDLE && start_i) begin
        k_q   <= rkey_i;
        dec_q <= DECRYPT_EN & dec_i;
        fin_q <= final_i;
        idx   <= 2'd0;
      end else if (hs) begin
        idx <= idx + 2'd1;
      end
      // Captured on entry to DONE so result_o is already valid while done_o is high.
      if (st_nxt == ST_DONE && st != ST_DONE) result_o <= s_nxt;
    end
  end

  assign busy_o         = (st != ST_IDLE);
  assign done_o         = (st == ST_DONE);
  assign word.req_valid = (st == ST_SUB) || (st == ST_MIX);
  assign word.req_mix   = (st == ST_MIX);
  assign word.req_dec   = dec_q;
  assign word.req_rs1   = s_q[COL_W*idx +: COL_W];

endmodule

// File: tb/tb_aes_v1_round_seq.sv
// Randomised scoreboard bench: a word-unit responder plus a whole-state AES round model.
module tb_aes_v1_round_seq;

  typedef struct packed {
    logic        mix;
    logic        dec;
    logic [31:0] rs1;
  } req_t;

  typedef struct packed {
    logic [127:0] result;
    logic [31:0]  due;
  } exp_t;

  logic clk;
  logic g_reset;
  logic start, dec_in, fin_in;
  logic [127:0] st_in, key_in;
  logic busy, done;
  logic [127:0] result;
  logic start2, dec2, fin2;
  logic [127:0] st2, k2;
  logic busy2, done2;
  logic [127:0] result2;

  aes_v1_round_seq_if w1();
  aes_v1_round_seq_if w2();

  aes_v1_round_seq #(.DECRYPT_EN(1'b1)) dut (
    .g_clk(clk), .g_reset(g_reset), .start_i(start), .dec_i(dec_in), .final_i(fin_in),
    .state_i(st_in), .rkey_i(key_in), .busy_o(busy), .done_o(done), .result_o(result),
    .word(w1)
  );

  aes_v1_round_seq #(.DECRYPT_EN(1'b0)) dut2 (
    .g_clk(clk), .g_reset(g_reset), .start_i(start2), .dec_i(dec2), .final_i(fin2),
    .state_i(st2), .rkey_i(k2), .busy_o(busy2), .done_o(done2), .result_o(result2),
    .word(w2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  int stall_n = 0;
  int wait_cnt = 0;
  bit track = 1'b1;
  logic [7:0] sbox [256];
  logic [7:0] isbox [256];
  logic [31:0] junk;
  logic junk_b;
  req_t req_q[$];
  exp_t exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] w, input logic inv);
    logic [7:0] a [4];
    logic [7:0] m0, m1, m2, m3;
    logic [31:0] o;
    for (int r = 0; r < 4; r++) a[r] = w[8*r +: 8];
    m0 = inv ? 8'h0e : 8'h02;
    m1 = inv ? 8'h0b : 8'h03;
    m2 = inv ? 8'h0d : 8'h01;
    m3 = inv ? 8'h09 : 8'h01;
    o = 32'h0;
    for (int r = 0; r < 4; r++)
      o[8*r +: 8] = gmul(m0, a[r]) ^ gmul(m1, a[(r+1)%4]) ^ gmul(m2, a[(r+2)%4]) ^ gmul(m3, a[(r+3)%4]);
    return o;
  endfunction

  function automatic logic [31:0] word_fn(input logic [31:0] w, input logic dec, input logic mix);
    logic [31:0] o;
    if (mix) o = mix_col(w, dec);
    else begin
      o = 32'h0;
      for (int r = 0; r < 4; r++) o[8*r +: 8] = dec ? isbox[w[8*r +: 8]] : sbox[w[8*r +: 8]];
    end
    return o;
  endfunction

  // Whole-state reference round; pre is the state presented to the MixColumns words.
  task automatic model_round(input logic [127:0] s, input logic [127:0] k, input logic dec,
                             input logic fin, output logic [127:0] res, output logic [127:0] pre);
    logic [7:0] b [16];
    logic [127:0] t;
    int src;
    for (int i = 0; i < 16; i++) b[i] = dec ? isbox[s[8*i +: 8]] : sbox[s[8*i +: 8]];
    t = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        src = dec ? (c - r + 4) % 4 : (c + r) % 4;
        t[8*(4*c + r) +: 8] = b[4*src + r];
      end
    if (dec) t = t ^ k;
    pre = t;
    if (!fin)
      for (int c = 0; c < 4; c++) t[32*c +: 32] = mix_col(t[32*c +: 32], dec);
    if (!dec) t = t ^ k;
    res = t;
  endtask

  // Responder for the full-featured instance, with an optional fixed stall per word.
  always @(posedge clk) begin
    junk   <= $urandom;
    junk_b <= 1'($urandom);
    if (g_reset || (w1.req_valid && w1.rsp_ready)) wait_cnt <= 0;
    else if (w1.req_valid) wait_cnt <= wait_cnt + 1;
  end

  always_comb begin
    w1.rsp_ready = w1.req_valid ? (wait_cnt >= stall_n) : junk_b;
    w1.rsp_rd    = (w1.req_valid && w1.rsp_ready) ? word_fn(w1.req_rs1, w1.req_dec, w1.req_mix) : junk;
  end

  always_comb begin
    w2.rsp_ready = w2.req_valid;
    w2.rsp_rd    = w2.req_valid ? word_fn(w2.req_rs1, w2.req_dec, w2.req_mix) : junk;
  end

  // Monitor: pops expected requests on each handshake and expected results on each done pulse.
  bit held_vld = 1'b0;
  logic [33:0] held;
  always @(negedge clk) begin
    req_t r;
    exp_t e;
    if (track) begin
      if (held_vld && w1.req_valid) chk("req_stable", {w1.req_mix, w1.req_dec, w1.req_rs1}, held);
      if (w1.req_valid && w1.rsp_ready) begin
        if (req_q.size() == 0) chk("req_extra", {w1.req_mix, w1.req_dec, w1.req_rs1}, 128'h0);
        else begin
          r = req_q.pop_front();
          chk("req_word", {w1.req_mix, w1.req_dec, w1.req_rs1}, r);
        end
      end
      held_vld = w1.req_valid && !w1.rsp_ready;
      held     = {w1.req_mix, w1.req_dec, w1.req_rs1};
    end else held_vld = 1'b0;
    if (done) begin
      done_cnt++;
      if (exp_q.size() == 0) chk("done_extra", 128'(done), 128'h0);
      else begin
        e = exp_q.pop_front();
        chk("result", result, e.result);
        chk("done_cycle", 128'(cyc), 128'(e.due));
      end
    end
  end

  task automatic push_reqs(input logic [127:0] s, input logic [127:0] pre, input logic dec, input logic fin);
    for (int c = 0; c < 4; c++) req_q.push_back('{mix: 1'b0, dec: dec, rs1: s[32*c +: 32]});
    if (!fin)
      for (int c = 0; c < 4; c++) req_q.push_back('{mix: 1'b1, dec: dec, rs1: pre[32*c +: 32]});
  endtask

  task automatic wait_done(input int target, input int budget);
    int n;
    n = 0;
    while (done_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt < target) chk("done_timeout", 128'(done_cnt), 128'(target));
  endtask

  task automatic run1(input logic [127:0] s, input logic [127:0] k, input logic dec, input logic fin,
                      input int stall, input logic [127:0] res, input logic [127:0] pre);
    int lat, target;
    @(negedge clk);
    stall_n = stall;
    start = 1'b1; st_in = s; key_in = k; dec_in = dec; fin_in = fin;
    lat = (fin ? 4 : 8) * (1 + stall) + 1;
    exp_q.push_back('{result: res, due: 32'(cyc + lat)});
    push_reqs(s, pre, dec, fin);
    target = done_cnt + 1;
    @(negedge clk);
    start = 1'b0;
    wait_done(target, 100);
    @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, 128'(busy), 128'h0);
    chk({tag, "_done"}, 128'(done), 128'h0);
    chk({tag, "_valid"}, 128'(w1.req_valid), 128'h0);
    chk({tag, "_mix"}, 128'(w1.req_mix), 128'h0);
    chk({tag, "_dec"}, 128'(w1.req_dec), 128'h0);
    chk({tag, "_rs1"}, 128'(w1.req_rs1), 128'h0);
    chk({tag, "_result"}, result, 128'h0);
  endtask

  task automatic run_dut2(input logic fin);
    logic [127:0] s, k, res, pre;
    int c0, n;
    bit dec_seen;
    s = {$urandom, $urandom, $urandom, $urandom};
    k = {$urandom, $urandom, $urandom, $urandom};
    model_round(s, k, 1'b0, fin, res, pre);
    @(negedge clk);
    start2 = 1'b1; st2 = s; k2 = k; dec2 = 1'b1; fin2 = fin;
    c0 = cyc; n = 0; dec_seen = 1'b0;
    @(negedge clk);
    start2 = 1'b0;
    while (!done2 && n < 40) begin
      if (w2.req_dec) dec_seen = 1'b1;
      @(negedge clk);
      n++;
    end
    chk("nodec_req_dec", 128'(dec_seen), 128'h0);
    if (!done2) chk("nodec_timeout", 128'(done2), 128'h1);
    else begin
      chk("nodec_result", result2, res);
      chk("nodec_cycle", 128'(cyc - c0), 128'(fin ? 5 : 9));
    end
    @(negedge clk);
  endtask

  initial begin
    logic [127:0] s, k, res, pre, s1, k1, r1;
    logic dec, fin;
    int c0, target;
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv, sv;
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sv = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sbox[x]  = sv;
      isbox[sv] = 8'(x);
    end
    g_reset = 1'b1;
    start = 1'b0; dec_in = 1'b0; fin_in = 1'b0; st_in = '0; key_in = '0;
    start2 = 1'b0; dec2 = 1'b0; fin2 = 1'b0; st2 = '0; k2 = '0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    chk("reset_busy2", 128'(busy2), 128'h0);
    g_reset = 1'b0;

    // FIPS-197 round 1, with the known ShiftRows output as the MixColumns operands.
    s1 = 128'h0848f8e9_2a8dc69a_2be2f4a0_bee33d19;
    k1 = 128'h05766c2a_3939a323_b12c5488_17fefaa0;
    r1 = 128'h49506a02_43ea5b6b_2b359f68_f27f9ca4;
    run1(s1, k1, 1'b0, 1'b0, 0, r1, 128'he598271e_f11141b8_ae52b4e0_305dbfd4);

    model_round(r1, k1, 1'b1, 1'b0, res, pre);
    run1(r1, k1, 1'b1, 1'b0, 0, res, pre);

    s = {$urandom, $urandom, $urandom, $urandom};
    k = {$urandom, $urandom, $urandom, $urandom};
    model_round(s, k, 1'b0, 1'b1, res, pre);
    run1(s, k, 1'b0, 1'b1, 2, res, pre);

    // start held high across a whole round: second round starts the cycle after DONE.
    s = {$urandom, $urandom, $urandom, $urandom};
    k = {$urandom, $urandom, $urandom, $urandom};
    model_round(s, k, 1'b0, 1'b0, res, pre);
    @(negedge clk);
    stall_n = 0;
    start = 1'b1; st_in = s; key_in = k; dec_in = 1'b0; fin_in = 1'b0;
    c0 = cyc;
    exp_q.push_back('{result: res, due: 32'(c0 + 9)});
    exp_q.push_back('{result: res, due: 32'(c0 + 19)});
    push_reqs(s, pre, 1'b0, 1'b0);
    push_reqs(s, pre, 1'b0, 1'b0);
    target = done_cnt + 2;
    repeat (19) @(negedge clk);
    start = 1'b0;
    wait_done(target, 40);
    @(negedge clk);

    // Reset during MIX, then a clean round.
    @(negedge clk);
    track = 1'b0;
    start = 1'b1; st_in = {$urandom, $urandom, $urandom, $urandom}; dec_in = 1'b0; fin_in = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    g_reset = 1'b1;
    @(negedge clk);
    check_zero("midreset");
    g_reset = 1'b0;
    track = 1'b1;
    s = {$urandom, $urandom, $urandom, $urandom};
    k = {$urandom, $urandom, $urandom, $urandom};
    model_round(s, k, 1'b0, 1'b0, res, pre);
    run1(s, k, 1'b0, 1'b0, 0, res, pre);

    run_dut2(1'b0);
    run_dut2(1'b1);

    for (int i = 0; i < 10; i++) begin
      s = {$urandom, $urandom, $urandom, $urandom};
      k = {$urandom, $urandom, $urandom, $urandom};
      dec = 1'($urandom);
      fin = 1'($urandom);
      model_round(s, k, dec, fin, res, pre);
      run1(s, k, dec, fin, $urandom_range(0, 2), res, pre);
    end

    repeat (3) @(negedge clk);
    chk("req_left", 128'(req_q.size()), 128'h0);
    chk("exp_left", 128'(exp_q.size()), 128'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
